burst_memory: RTL and testbench
===============================

# burst_memory

Parametrised, byte-addressable, single-port memory model with word bursts and byte-enable writes. Supersedes the fixed 32-bit memory in the processor simulation environment. It adds configurable data width, depth and base address, a state-machine-driven burst engine for 1/4/8/16-word accesses, registered read data with a valid strobe, and address range checking. Instruction fetch and the load/store unit connect to it directly.

## Interface
- DATA_WIDTH, 32, word width in bits; multiple of 8; BPW = DATA_WIDTH/8 bytes per word
- ADDR_WIDTH, 32, byte address width
- DEPTH_BYTES, 1048576, memory size in bytes
- START_ADDR, 32'h80020000, byte address mapped to memory byte 0
- clock  in  1  single clock; all state changes on posedge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  command request; sampled only while busy=0
- rw  in  1  1 = read, 0 = write; latched at accept
- address  in  ADDR_WIDTH  burst start byte address; latched at accept
- access_size  in  2  00 = 1 word, 01 = 4, 10 = 8, 11 = 16; latched at accept
- data_in  in  DATA_WIDTH  write data for the current beat
- byte_en  in  BPW  per-byte write mask for the current beat; bit i gates data_in[8i+7:8i]
- busy  out  1  burst in progress; new commands ignored
- data_out  out  DATA_WIDTH  registered read data
- data_valid  out  1  data_out holds a valid read beat this cycle
- error  out  1  one-cycle pulse when a command is rejected

## Operation
- Byte storage mem[0:DEPTH_BYTES-1] of 8 bits. Order is little-endian: data bits [7:0] map to the lowest byte address.
- Offset = address - START_ADDR, in ADDR_WIDTH-bit arithmetic. Burst length L is 1, 4, 8 or 16 words.
- Accept: at a posedge with enable=1, busy=0 and not in reset.
- Reject conditions: address not BPW-aligned, or offset + L*BPW > DEPTH_BYTES. Offset underflow counts as out of range.
- On reject: error=1 for exactly one cycle; no memory access; busy stays 0.
- No wrap-around. Out-of-range bursts are rejected whole.
- FSM states are IDLE, READ and WRITE. Internal state: cur_addr (byte offset) and beat counter cnt.
- IDLE, accepted read:
  - cur_addr <= offset, cnt <= 0
  - go to READ
- IDLE, accepted write:
  - beat 0 is written at the accept edge, using data_in and byte_en
  - if L=1, stay in IDLE
  - otherwise cur_addr <= offset+BPW, cnt <= 1, go to WRITE
- READ, each edge:
  - data_out <= word at cur_addr, data_valid <= 1
  - cur_addr += BPW, cnt++
  - after the beat where cnt = L-1, go to IDLE
- WRITE, each edge:
  - write data_in under byte_en at cur_addr
  - cur_addr += BPW, cnt++
  - after the beat where cnt = L-1, go to IDLE
  - the source presents a new word every cycle while busy=1; there is no stall
- busy = (state != IDLE), registered.
- data_valid is 0 in every cycle that does not follow a READ edge. data_out holds its last value when data_valid=0.
- enable, rw, address and access_size are ignored while busy=1. They do not trigger error.
- byte_en = 0 makes the beat a no-op, but the beat is still consumed.

## Timing
- Reset (reset_n=0, asynchronous) forces all outputs to 0 immediately:
  - state=IDLE, busy=0, data_out=0, data_valid=0, error=0, cur_addr=0, cnt=0
  - memory contents are not cleared
- Reset mid-burst aborts the burst. Bytes already written are kept.
- Read: accept at edge 0; beat k appears on data_out after edge k+1, for k = 0..L-1, with data_valid=1.
  - busy=1 after edges 0..L-1 and 0 after edge L, which is the cycle carrying the last beat
  - earliest next accept is edge L+1
- Write: beat k is sampled at edge k.
  - busy=1 after edges 0..L-2 and 0 after edge L-1
  - L=1 writes leave busy at 0; back-to-back single writes run every cycle
- Error pulse appears in the cycle after the rejecting edge.

## Test plan
- Reset: assert reset_n=0 during beat 3 of a 16-word read -> busy, data_valid, data_out and error drop to 0 without a clock edge; after release, a new read is accepted.
- Single word: write 0xDEADBEEF at 0x80020000 with byte_en=4'hF, then read L=1 -> mem[0]=0xEF, mem[3]=0xDE; data_out=0xDEADBEEF with data_valid one cycle after accept; busy high for one cycle.
- Burst: 16-word write at 0x80020040 with data 0x100+k, then a 16-word read -> 16 consecutive data_valid cycles returning 0x100..0x10F in order; busy high for exactly 16 cycles.
- Byte enable: write 0xAABBCCDD, then write 0x11223344 with byte_en=4'b0101 at the same address -> read returns 0xAA22CC44.
- Errors: read at 0x80020002 -> one-cycle error, busy=0, no data_valid. Read at START_ADDR+DEPTH_BYTES-16 with access_size=01 -> accepted. Same address with access_size=10 -> error. Write at 0x80010000 -> error, memory unchanged.
- Ignore while busy: pulse enable with an illegal address during an 8-word read -> no error, read beats unchanged; the next command is accepted one cycle after the last beat.

Source files
------------

// File: rtl/burst_memory.sv
// burst_memory
//   Byte-addressable single-port memory model with 1/4/8/16-word bursts,
//   per-byte write enables, registered read data and address range checking.
//
// Ports
//   clock        : single clock, all state changes on the rising edge
//   reset_n      : asynchronous active-low reset (memory contents are kept)
//   enable       : command request, sampled only while busy=0
//   rw           : 1 = read, 0 = write (latched at accept)
//   address      : burst start byte address (latched at accept)
//   access_size  : 00 = 1 word, 01 = 4, 10 = 8, 11 = 16 (latched at accept)
//   data_in      : write data for the current beat
//   byte_en      : per-byte write mask for the current beat
//   busy         : burst in progress, new commands ignored
//   data_out     : registered read data
//   data_valid   : data_out carries a read beat this cycle
//   error        : one-cycle pulse when a command is rejected
module burst_memory #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DEPTH_BYTES = 1048576,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR  = 32'h8002_0000
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    rw,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [1:0]              access_size,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  output logic                    busy,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    data_valid,
  output logic                    error
);

  localparam int unsigned BPW   = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

  // One extra bit so offset + burst span cannot overflow before the range compare.
  typedef logic [ADDR_WIDTH:0] ext_t;
  typedef logic [IDX_W-1:0]    idx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  function automatic logic [4:0] burst_words(input logic [1:0] size);
    logic [4:0] words;
    case (size)
      2'b00:   words = 5'd1;
      2'b01:   words = 5'd4;
      2'b10:   words = 5'd8;
      default: words = 5'd16;
    endcase
    return words;
  endfunction

  state_t                 state_r;
  logic [ADDR_WIDTH-1:0]  cur_addr_r;
  logic [3:0]             cnt_r;
  logic [3:0]             last_r;
  logic                   busy_r;
  logic [DATA_WIDTH-1:0]  data_out_r;
  logic                   data_valid_r;
  logic                   error_r;
  logic [7:0]             mem_r [DEPTH_BYTES];

  logic [ADDR_WIDTH-1:0]  offset_s;
  ext_t                   end_s;
  logic                   reject_s;
  logic [3:0]             req_last_s;
  logic [DATA_WIDTH-1:0]  rd_word_s;
  logic                   wr_en_s;
  logic [ADDR_WIDTH-1:0]  wr_base_s;

  // Command decode: offset from the mapped base, alignment and range check.
  // A base address above the request wraps the offset to a huge value, so
  // underflow falls out as out-of-range.
  always_comb begin
    offset_s   = address - START_ADDR;
    end_s      = ext_t'(offset_s) + ext_t'(burst_words(access_size)) * ext_t'(BPW);
    reject_s   = ((address % ADDR_WIDTH'(BPW)) != {ADDR_WIDTH{1'b0}}) ||
                 (end_s > ext_t'(DEPTH_BYTES));
    req_last_s = 4'(burst_words(access_size) - 5'd1);
  end

  // Little-endian word assembly from the current burst address.
  always_comb begin
    rd_word_s = {DATA_WIDTH{1'b0}};
    for (int unsigned i = 0; i < BPW; i++) begin
      rd_word_s[8*i +: 8] = mem_r[idx_t'(cur_addr_r + ADDR_WIDTH'(i))];
    end
  end

  // Write beat select: beat 0 lands on the accept edge at the decoded offset,
  // later beats follow the burst address register.
  always_comb begin
    if (state_r == ST_IDLE) begin
      wr_base_s = offset_s;
      wr_en_s   = reset_n & enable & ~rw & ~reject_s;
    end else begin
      wr_base_s = cur_addr_r;
      wr_en_s   = reset_n & (state_r == ST_WRITE);
    end
  end

  // Byte storage; deliberately not reset so contents survive a reset.
  always_ff @(posedge clock) begin
    if (wr_en_s) begin
      for (int unsigned i = 0; i < BPW; i++) begin
        if (byte_en[i]) begin
          mem_r[idx_t'(wr_base_s + ADDR_WIDTH'(i))] <= data_in[8*i +: 8];
        end
      end
    end
  end

  // Burst engine: command accept/reject, beat sequencing and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      cur_addr_r   <= {ADDR_WIDTH{1'b0}};
      cnt_r        <= 4'd0;
      last_r       <= 4'd0;
      busy_r       <= 1'b0;
      data_out_r   <= {DATA_WIDTH{1'b0}};
      data_valid_r <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      data_valid_r <= 1'b0;
      error_r      <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (enable) begin
            if (reject_s) begin
              error_r <= 1'b1;
            end else if (rw) begin
              cur_addr_r <= offset_s;
              cnt_r      <= 4'd0;
              last_r     <= req_last_s;
              state_r    <= ST_READ;
              busy_r     <= 1'b1;
            end else if (req_last_s != 4'd0) begin
              // Beat 0 already written this edge; continue from beat 1.
              cur_addr_r <= offset_s + ADDR_WIDTH'(BPW);
              cnt_r      <= 4'd1;
              last_r     <= req_last_s;
              state_r    <= ST_WRITE;
              busy_r     <= 1'b1;
            end
          end
        end
        ST_READ: begin
          data_out_r   <= rd_word_s;
          data_valid_r <= 1'b1;
          cur_addr_r   <= cur_addr_r + ADDR_WIDTH'(BPW);
          cnt_r        <= cnt_r + 4'd1;
          if (cnt_r == last_r) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_WRITE: begin
          cur_addr_r <= cur_addr_r + ADDR_WIDTH'(BPW);
          cnt_r      <= cnt_r + 4'd1;
          if (cnt_r == last_r) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign data_out   = data_out_r;
  assign data_valid = data_valid_r;
  assign error      = error_r;

endmodule

// File: tb/tb_burst_memory.sv
// tb_burst_memory
//   Directed plus randomized stimulus for burst_memory, checked against a
//   byte-level reference memory and plain-arithmetic accept/reject rules.
module tb_burst_memory;

  localparam longint START = 64'h8002_0000;
  localparam longint DEPTH = 1048576;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        rw = 1'b0;
  logic [31:0] address = 32'd0;
  logic [1:0]  access_size = 2'd0;
  logic [31:0] data_in = 32'd0;
  logic [3:0]  byte_en = 4'd0;
  logic        busy;
  logic [31:0] data_out;
  logic        data_valid;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ref_mem [longint];
  logic [31:0] wq [$];
  logic [3:0]  beq [$];
  logic [31:0] last_rd;

  burst_memory dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .rw          (rw),
    .address     (address),
    .access_size (access_size),
    .data_in     (data_in),
    .byte_en     (byte_en),
    .busy        (busy),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .error       (error)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int blen(input logic [1:0] sz);
    int n;
    n = 1;
    if (sz == 2'b01) n = 4;
    if (sz == 2'b10) n = 8;
    if (sz == 2'b11) n = 16;
    return n;
  endfunction

  function automatic bit model_reject(input logic [31:0] a, input int n);
    longint off;
    off = longint'(a) - START;
    return ((a % 4) != 0) || (off < 0) || (off + 4 * n > DEPTH);
  endfunction

  function automatic void model_write(input longint off, input logic [31:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[off + b] = d[8*b +: 8];
  endfunction

  function automatic logic [31:0] model_read(input longint off);
    logic [31:0] w;
    for (int b = 0; b < 4; b++)
      w[8*b +: 8] = ref_mem.exists(off + b) ? ref_mem[off + b] : 8'hxx;
    return w;
  endfunction

  task automatic fill_random(input int n, input bit full_be);
    wq.delete();
    beq.delete();
    for (int k = 0; k < n; k++) begin
      wq.push_back($urandom);
      beq.push_back(full_be ? 4'hF : 4'($urandom_range(15, 0)));
    end
  endtask

  task automatic write_burst(input logic [31:0] a, input logic [1:0] sz);
    int     n;
    bit     rej;
    longint off;
    n   = blen(sz);
    rej = model_reject(a, n);
    off = longint'(a) - START;
    enable = 1'b1; rw = 1'b0; address = a; access_size = sz;
    data_in = wq[0]; byte_en = beq[0];
    tick();
    enable = 1'b0;
    if (rej) begin
      chk("wr_reject_error", 64'(error), 64'd1);
      chk("wr_reject_busy", 64'(busy), 64'd0);
      tick();
      chk("wr_error_one_cycle", 64'(error), 64'd0);
    end else begin
      chk("wr_accept_error", 64'(error), 64'd0);
      model_write(off, wq[0], beq[0]);
      for (int k = 1; k < n; k++) begin
        chk("wr_busy_mid", 64'(busy), 64'd1);
        data_in = wq[k]; byte_en = beq[k];
        tick();
        model_write(off + 4 * k, wq[k], beq[k]);
      end
      chk("wr_busy_done", 64'(busy), 64'd0);
    end
  endtask

  task automatic read_burst(input logic [31:0] a, input logic [1:0] sz, input bit noise);
    int     n;
    bit     rej;
    longint off;
    n   = blen(sz);
    rej = model_reject(a, n);
    off = longint'(a) - START;
    enable = 1'b1; rw = 1'b1; address = a; access_size = sz;
    tick();
    enable = 1'b0;
    if (rej) begin
      chk("rd_reject_error", 64'(error), 64'd1);
      chk("rd_reject_busy", 64'(busy), 64'd0);
      chk("rd_reject_valid", 64'(data_valid), 64'd0);
      tick();
      chk("rd_error_one_cycle", 64'(error), 64'd0);
      chk("rd_reject_no_valid", 64'(data_valid), 64'd0);
    end else begin
      chk("rd_accept_busy", 64'(busy), 64'd1);
      chk("rd_accept_valid", 64'(data_valid), 64'd0);
      for (int k = 0; k < n; k++) begin
        if (noise) begin
          enable = 1'b1; rw = 1'b0; address = 32'h8002_0002; access_size = 2'b11;
        end
        tick();
        enable = 1'b0;
        chk("rd_beat_valid", 64'(data_valid), 64'd1);
        chk("rd_beat_data", 64'(data_out), 64'(model_read(off + 4 * k)));
        chk("rd_beat_busy", 64'(busy), (k < n - 1) ? 64'd1 : 64'd0);
        chk("rd_beat_error", 64'(error), 64'd0);
      end
      last_rd = data_out;
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int          n;
    int          off;

    // Reset state
    tick(); tick(); tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(data_valid), 64'd0);
    chk("rst_data", 64'(data_out), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    reset_n = 1'b1;
    tick();

    // Initialise the first 4 KiB with random words
    for (int b = 0; b < 64; b++) begin
      fill_random(16, 1'b1);
      write_burst(32'(START + 64 * b), 2'b11);
    end

    // Single word write/read
    wq = '{32'hDEAD_BEEF}; beq = '{4'hF};
    write_burst(32'h8002_0000, 2'b00);
    chk("mem0", 64'(dut.mem_r[0]), 64'hEF);
    chk("mem3", 64'(dut.mem_r[3]), 64'hDE);
    read_burst(32'h8002_0000, 2'b00, 1'b0);
    chk("single_const", 64'(last_rd), 64'hDEAD_BEEF);
    tick();
    chk("idle_valid_low", 64'(data_valid), 64'd0);
    chk("idle_data_hold", 64'(data_out), 64'hDEAD_BEEF);

    // 16-word burst with incrementing data
    wq.delete(); beq.delete();
    for (int k = 0; k < 16; k++) begin
      wq.push_back(32'h100 + 32'(k));
      beq.push_back(4'hF);
    end
    write_burst(32'h8002_0040, 2'b11);
    read_burst(32'h8002_0040, 2'b11, 1'b0);
    chk("burst_last_const", 64'(last_rd), 64'h10F);

    // Byte-enable merge
    wq = '{32'hAABB_CCDD}; beq = '{4'hF};
    write_burst(32'h8002_0080, 2'b00);
    wq = '{32'h1122_3344}; beq = '{4'b0101};
    write_burst(32'h8002_0080, 2'b00);
    read_burst(32'h8002_0080, 2'b00, 1'b0);
    chk("byte_en_const", 64'(last_rd), 64'hAA22_CC44);

    // Back-to-back single writes, one per cycle, then a 4-word read
    for (int k = 0; k < 4; k++) begin
      wq = '{32'hC0DE_0000 + 32'(k)}; beq = '{4'hF};
      write_burst(32'(START + 32'h100 + 4 * k), 2'b00);
    end
    read_burst(32'(START + 32'h100), 2'b01, 1'b0);
    chk("b2b_last_const", 64'(last_rd), 64'hC0DE_0003);

    // Range and alignment errors
    read_burst(32'h8002_0002, 2'b00, 1'b0);
    fill_random(4, 1'b1);
    write_burst(32'(START + DEPTH - 16), 2'b01);
    read_burst(32'(START + DEPTH - 16), 2'b01, 1'b0);
    read_burst(32'(START + DEPTH - 16), 2'b10, 1'b0);
    fill_random(1, 1'b1);
    write_burst(32'(START + 32'hF_0000), 2'b00);
    wq = '{32'h5555_AAAA}; beq = '{4'hF};
    write_burst(32'h8001_0000, 2'b00);
    read_burst(32'(START + 32'hF_0000), 2'b00, 1'b0);

    // Commands ignored while busy; next command accepted right after last beat
    read_burst(32'h8002_0040, 2'b10, 1'b1);
    read_burst(32'h8002_0000, 2'b00, 1'b0);

    // Reset in the middle of a 16-word read
    enable = 1'b1; rw = 1'b1; address = 32'h8002_0040; access_size = 2'b11;
    tick();
    enable = 1'b0;
    tick(); tick(); tick(); tick();
    chk("pre_reset_beat3", 64'(data_out), 64'h103);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_valid", 64'(data_valid), 64'd0);
    chk("async_rst_data", 64'(data_out), 64'd0);
    chk("async_rst_error", 64'(error), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    read_burst(32'h8002_0040, 2'b01, 1'b0);

    // Randomized mix inside the initialised region, with some illegal addresses
    for (int t = 0; t < 40; t++) begin
      sz  = 2'($urandom_range(3, 0));
      n   = blen(sz);
      off = 4 * int'($urandom_range(32'(1024 - n), 0));
      a   = 32'(START + off);
      if ($urandom_range(7, 0) == 0) begin
        a = ($urandom_range(1, 0) == 1) ? (a + 32'd1) : 32'(START + DEPTH - 4 * (n - 1));
      end
      if ($urandom_range(1, 0) == 1) begin
        read_burst(a, sz, 1'($urandom_range(1, 0)));
      end else begin
        fill_random(n, 1'b0);
        write_burst(a, sz);
      end
    end

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
